// File: rtl/wb_dbg_fanout.sv
// rtl/wb_dbg_fanout.sv - Wishbone debug-bus fan-out to up to three cores plus a control/status CSR window.
// One transaction in flight; unresponsive cores are timed out and flagged.
module wb_dbg_fanout #(
    parameter int NCORES  = 3,
    parameter int SEL_LSB = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wbs_cyc,
    input  logic                   i_wbs_stb,
    input  logic                   i_wbs_we,
    input  logic [31:0]            i_wbs_adr,
    input  logic [31:0]            i_wbs_dat,
    input  logic [3:0]             i_wbs_sel,
    output logic [31:0]            o_wbs_rdt,
    output logic                   o_wbs_ack,
    output logic [31:0]            o_dbg_adr,
    output logic [31:0]            o_dbg_dat,
    output logic [3:0]             o_dbg_sel,
    output logic                   o_dbg_we,
    output logic [NCORES-1:0]      o_dbg_stb,
    input  logic [32*NCORES-1:0]   i_dbg_rdt,
    input  logic [NCORES-1:0]      i_dbg_ack,
    output logic [NCORES-1:0]      o_debug_mode,
    output logic [NCORES-1:0]      o_core_rst
);

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

    localparam logic [1:0]  CSR_T   = 2'd3;
    localparam logic [2:0]  NC3     = 3'(NCORES);
    localparam logic [7:0]  TO_LIM  = 8'(TIMEOUT);
    localparam logic [31:0] ID_WORD = {16'h0, 8'(NCORES), 8'h01};

    state_t              state, state_d;
    logic [1:0]          req_t, tgt;
    logic                req_core, req_csr, csr_hit;
    logic [NCORES-1:0]   req_onehot;
    logic [NCORES-1:0]   debug_mode, core_rst, to_flag;
    logic [7:0]          cnt;
    logic [31:0]         core_rdt, csr_rdt;
    logic                core_ack;
    logic                accept, fwd_ack, fwd_to, fwd_abort;

    assign req_t    = i_wbs_adr[SEL_LSB+1:SEL_LSB];
    assign req_core = {1'b0, req_t} < NC3;
    assign req_csr  = req_t == CSR_T;

    assign o_wbs_ack    = state == RESP;
    assign o_debug_mode = debug_mode;
    assign o_core_rst   = core_rst;

    always_comb begin
        req_onehot = '0;
        core_rdt   = 32'h0;
        core_ack   = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            if (req_t == 2'(k)) req_onehot[k] = 1'b1;
            // Only the selected core's ack is honoured; others are ignored.
            if (tgt == 2'(k)) begin
                core_rdt = i_dbg_rdt[32*k +: 32];
                core_ack = i_dbg_ack[k];
            end
        end
    end

    always_comb begin
        case (i_wbs_adr[3:2])
            2'd0:    csr_rdt = 32'(debug_mode);
            2'd1:    csr_rdt = 32'(core_rst);
            2'd2:    csr_rdt = 32'(to_flag);
            default: csr_rdt = ID_WORD;
        endcase
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        fwd_ack   = 1'b0;
        fwd_to    = 1'b0;
        fwd_abort = 1'b0;
        case (state)
            IDLE: begin
                if (i_wbs_cyc && i_wbs_stb) begin
                    accept  = 1'b1;
                    state_d = req_core ? FWD : RESP;
                end
            end
            FWD: begin
                // A master abort beats a same-cycle ack; an ack beats a timeout.
                if (!i_wbs_cyc) begin
                    fwd_abort = 1'b1;
                    state_d   = IDLE;
                end else if (core_ack) begin
                    fwd_ack = 1'b1;
                    state_d = RESP;
                end else if (cnt == TO_LIM) begin
                    fwd_to  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wbs_rdt  <= 32'h0;
            o_dbg_adr  <= 32'h0;
            o_dbg_dat  <= 32'h0;
            o_dbg_sel  <= 4'h0;
            o_dbg_we   <= 1'b0;
            o_dbg_stb  <= '0;
            tgt        <= 2'd0;
            csr_hit    <= 1'b0;
            cnt        <= 8'd0;
            debug_mode <= '1;
            core_rst   <= '0;
            to_flag    <= '0;
        end else begin
            if (accept) begin
                o_dbg_adr <= i_wbs_adr;
                o_dbg_dat <= i_wbs_dat;
                o_dbg_sel <= i_wbs_sel;
                o_dbg_we  <= i_wbs_we;
                tgt       <= req_t;
                csr_hit   <= req_csr;
                cnt       <= 8'd0;
                if (req_core) o_dbg_stb <= req_onehot;
                else          o_dbg_rdt_load();
            end
            if (state == FWD) cnt <= cnt + 8'd1;
            if (fwd_ack) begin
                o_wbs_rdt <= core_rdt;
                o_dbg_stb <= '0;
            end
            if (fwd_to) begin
                o_wbs_rdt <= 32'hDEAD_BEEF;
                to_flag   <= to_flag | o_dbg_stb;
                o_dbg_stb <= '0;
            end
            if (fwd_abort) o_dbg_stb <= '0;
            // CSR writes land on the edge that ends the ack cycle.
            if (state == RESP && csr_hit && o_dbg_we) begin
                case (o_dbg_adr[3:2])
                    2'd0:    debug_mode <= o_dbg_dat[NCORES-1:0];
                    2'd1:    core_rst   <= o_dbg_dat[NCORES-1:0];
                    2'd2:    to_flag    <= to_flag & ~o_dbg_dat[NCORES-1:0];
                    default: ;
                endcase
            end
        end
    end

    // CSR reads are captured at accept; unmapped targets read as zero.
    task automatic o_dbg_rdt_load();
        o_wbs_rdt <= req_csr ? csr_rdt : 32'h0;
    endtask

endmodule

// File: doc/wb_dbg_fanout.md
# wb_dbg_fanout

Wishbone debug-bus fan-out between the Caravel management Wishbone slave port and the debug ports of up to three `subservient` cores. It decodes a target field in the address and forwards one transaction at a time to the selected core. It returns that core's read data and ack as the single `wbs_dat_o`/`wbs_ack_o` pair, so the three cores no longer drive the shared outputs directly. It also owns a small CSR window that drives each core's `i_debug_mode` and a per-core soft reset, and it records timeouts of unresponsive cores.

## Interface
- `NCORES`, 3 — number of attached cores, 1..3.
- `SEL_LSB`, 24 — target field is `i_wbs_adr[SEL_LSB+1:SEL_LSB]`.
- `TIMEOUT`, 255 — cycles a forwarded access may wait for a core ack, 1..255.

- `i_clk` in 1 — single clock (`wb_clk_i`).
- `i_rst` in 1 — asynchronous, active-high reset (`wb_rst_i`).
- `i_wbs_cyc`, `i_wbs_stb`, `i_wbs_we` in 1 — upstream Wishbone classic controls.
- `i_wbs_adr` in 32; `i_wbs_dat` in 32; `i_wbs_sel` in 4 — upstream request.
- `o_wbs_rdt` out 32; `o_wbs_ack` out 1 — upstream response.
- `o_dbg_adr` out 32; `o_dbg_dat` out 32; `o_dbg_sel` out 4; `o_dbg_we` out 1 — registered request, shared by all cores.
- `o_dbg_stb` out NCORES — per-core strobe, one-hot or zero.
- `i_dbg_rdt` in 32*NCORES — core k read data at bits [32k+31:32k].
- `i_dbg_ack` in NCORES — per-core ack.
- `o_debug_mode` out NCORES — to each core's `i_debug_mode`.
- `o_core_rst` out NCORES — per-core soft reset, ORed with `i_rst` outside this block.

## Operation
- Target decode on `t = i_wbs_adr[SEL_LSB+1:SEL_LSB]`:
  - `t < NCORES`: core t.
  - `t == 3`: CSR window.
  - Otherwise: unmapped.
- FSM states IDLE, FWD, RESP.
- **IDLE**
  - On `i_wbs_cyc & i_wbs_stb`, register adr/dat/sel/we into `o_dbg_*`.
  - Core target: go to FWD, set `o_dbg_stb[t]`, clear the timeout counter.
  - CSR or unmapped target: perform the access and go to RESP.
- **FWD**
  - Hold `o_dbg_stb[t]` and `o_dbg_*` stable.
  - On `i_dbg_ack[t]`: capture `i_dbg_rdt[t]`, drop the strobe, go to RESP.
  - Counter reaches `TIMEOUT` with no ack: capture `32'hDEAD_BEEF`, set sticky `to_flag[t]`, drop the strobe, go to RESP.
  - `i_wbs_cyc` low (abort): drop the strobe, return to IDLE with no upstream ack.
  - Ack and timeout on the same cycle: the ack wins and no flag is set.
- **RESP**
  - `o_wbs_ack` = 1 for exactly one cycle with captured `o_wbs_rdt`, then IDLE.
  - The master deasserts `stb` the cycle after the ack; IDLE never accepts during RESP.
- CSR window, offset `i_wbs_adr[3:2]`; byte selects are ignored and whole-word writes apply.
  - 0: `debug_mode[NCORES-1:0]`, RW.
  - 1: `core_rst[NCORES-1:0]`, RW.
  - 2: `to_flag[NCORES-1:0]`; reads the flags, writing 1 clears that bit (W1C).
  - 3: reads constant `{16'h0, 8'(NCORES), 8'h01}` (ID/version); writes are ignored.
  - Unused upper read bits are 0.
- CSR writes take effect at the RESP clock edge.
- A W1C clear and a timeout set on the same cycle cannot coincide, because only one transaction is in flight at a time.
- Unmapped reads return `32'h0`; unmapped writes are dropped.
- Ack from a non-selected core, or any ack outside FWD, is ignored.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - `o_wbs_ack` 0; `o_wbs_rdt` 0.
  - `o_dbg_stb` 0; `o_dbg_adr`/`o_dbg_dat`/`o_dbg_sel`/`o_dbg_we` 0.
  - `debug_mode` all 1; `core_rst` all 0; `to_flag` 0.
- Reset mid-FWD drops the strobe immediately; no upstream ack is issued.
- CSR/unmapped latency: request sampled at edge 0, `o_wbs_ack` high in cycle 1.
- Core latency: `o_dbg_stb` high from cycle 1; a core ack in cycle 1+d gives `o_wbs_ack` in cycle 2+d.
- Timeout latency: `o_wbs_ack` at cycle `TIMEOUT`+2.
- `o_wbs_rdt` is valid only while `o_wbs_ack` = 1; it holds its value otherwise.
- At most one transaction is in flight; no pipelining.

## Test plan
- Reset, then read CSR 0 at `t=3`, offset 0 → ack in cycle 1, rdt `32'h7`. Write `32'h2` → `o_debug_mode` = `3'b010` after the ack cycle.
- Write `32'h1234_5678` to core 1 (`adr=32'h0100_0040`, `sel=4'hF`); core acks 3 cycles after its strobe:
  - `o_dbg_stb` = `3'b010` for exactly those cycles, with adr/dat matching.
  - `o_wbs_ack` one cycle later.
  - cores 0 and 2 never strobed.
- Read core 2 and never ack → ack at cycle 257, rdt `32'hDEAD_BEEF`, CSR 2 reads `32'h4`. Write `32'h4` to CSR 2 → it reads 0.
- Read core 0; drop `i_wbs_cyc` 2 cycles into FWD → strobe drops the next cycle, no `o_wbs_ack`, and the next CSR read completes normally.
- Spurious `i_dbg_ack[2]` while core 0 is pending → ignored; the core 0 ack completes with core 0 data. With `NCORES`=2, a read at `t=2` → ack in cycle 1 with rdt 0.
- Assert `i_rst` during FWD → `o_dbg_stb` = 0 in the same cycle and CSRs return to reset values.
